// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwb_pkg
// Description : Shared constants and types for the register-file write-back
//               scheduler: destination-mux select codes, fixed register
//               indices, write-back source indices and the stage state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regwb_pkg;

    // Number of write-back sources sharing the register-file write port.
    localparam int NUM_SRC = 4;

    // Destination-mux select codes.
    localparam logic [1:0] SEL_RD = 2'b00;
    localparam logic [1:0] SEL_RT = 2'b01;
    localparam logic [1:0] SEL_RA = 2'b10;
    localparam logic [1:0] SEL_SP = 2'b11;

    // Architectural register indices with a fixed role.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;
    localparam int REG_SP   = 29;

    // Write-back source indices (bit positions in req_valid / req_ready).
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;
    localparam logic [1:0] SRC_SP   = 2'd3;

    // One-entry output stage occupancy.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_t;

endpackage : regwb_pkg
`default_nettype wire

// File: rtl/regfile_wb_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-way round-robin arbiter. Searches the request vector
//               starting at the pointer position and grants the first
//               requester found. Purely combinational.
// Ports       : req        in  4  request vector
//               ptr        in  2  highest-priority position this cycle
//               grant      out 4  one-hot grant (all zero when no request)
//               grant_idx  out 2  binary index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import regwb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [1:0]         grant_idx
);

    logic [1:0] idx;
    logic       found;

    // Walk the four positions in priority order; the 2-bit index wraps
    // naturally, so ptr + k visits ptr, ptr+1, ... modulo 4.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = ptr;
        found     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter4
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the single register-file write port between four
//               write-back sources (ALU, load, jump-and-link, stack pointer).
//               One source is granted per cycle in round-robin order and its
//               write is held in a one-entry output stage that drives the
//               destination-mux controls, write enable and write data.
// Ports       : clock        in  1       system clock
//               reset_n      in  1       asynchronous active-low reset
//               req_valid    in  4       per-source write request
//               req_ready    out 4       per-source accept (one-hot or zero)
//               alu_rd       in  REG_W   ALU destination register
//               alu_data     in  DATA_W  ALU result
//               mem_rt       in  REG_W   load destination register
//               mem_data     in  DATA_W  load data
//               link_data    in  DATA_W  return address for $31
//               sp_data      in  DATA_W  new stack pointer for $29
//               wb_stall     in  1       freeze the write port
//               reg_write    out 1       register-file write enable
//               reg_dst_sel  out 2       destination-mux select
//               reg_dst_in0  out REG_W   destination-mux input 0 (rd)
//               reg_dst_in1  out REG_W   destination-mux input 1 (rt)
//               reg_wdata    out DATA_W  register-file write data
//               busy         out 1       output stage occupied
//               wr_count     out 16      completed writes, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
    import regwb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
)
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] req_valid,
    output logic [NUM_SRC-1:0] req_ready,
    input  logic [REG_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic [REG_W-1:0]   mem_rt,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic [DATA_W-1:0]  link_data,
    input  logic [DATA_W-1:0]  sp_data,
    input  logic               wb_stall,
    output logic               reg_write,
    output logic [1:0]         reg_dst_sel,
    output logic [REG_W-1:0]   reg_dst_in0,
    output logic [REG_W-1:0]   reg_dst_in1,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               busy,
    output logic [15:0]        wr_count
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);
    localparam logic [REG_W-1:0] RA_IDX   = REG_W'(REG_RA);
    localparam logic [REG_W-1:0] SP_IDX   = REG_W'(REG_SP);

    wb_state_t           state;
    wb_state_t           state_next;
    logic [1:0]          rr_ptr;
    logic [NUM_SRC-1:0]  grant;
    logic [1:0]          grant_idx;
    logic                can_load;
    logic                accept;
    logic [DATA_W-1:0]   load_data;
    logic [REG_W-1:0]    eff_dst;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter4 u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The stage can take a new write when empty, or when full and draining
    // this cycle. reset_n gates ready so it reads zero while reset is held,
    // even though the EMPTY state would otherwise allow a grant.
    assign can_load  = (state == EMPTY) || !wb_stall;
    assign req_ready = (reset_n && can_load) ? grant : '0;
    assign accept    = |req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 2'd0;
        end else if (accept) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                // Stalled: hold. Draining: refill if a new write is accepted
                // in the same cycle, otherwise go empty.
                if (!wb_stall && !accept) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign busy = (state == FULL);

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_comb begin
        load_data = alu_data;
        unique case (grant_idx)
            SRC_ALU:  load_data = alu_data;
            SRC_MEM:  load_data = mem_data;
            SRC_LINK: load_data = link_data;
            SRC_SP:   load_data = sp_data;
            default:  load_data = alu_data;
        endcase
    end

    // Only the register field belonging to the granted source is updated;
    // the other field keeps its old value so the mux inputs stay quiet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_dst_sel <= SEL_RD;
            reg_dst_in0 <= '0;
            reg_dst_in1 <= '0;
            reg_wdata   <= '0;
        end else if (accept) begin
            unique case (grant_idx)
                SRC_ALU: begin
                    reg_dst_sel <= SEL_RD;
                    reg_dst_in0 <= alu_rd;
                end
                SRC_MEM: begin
                    reg_dst_sel <= SEL_RT;
                    reg_dst_in1 <= mem_rt;
                end
                SRC_LINK: reg_dst_sel <= SEL_RA;
                SRC_SP:   reg_dst_sel <= SEL_SP;
                default:  reg_dst_sel <= SEL_RD;
            endcase
            reg_wdata <= load_data;
        end
    end

    // Destination the register file will actually see after the mux.
    always_comb begin
        eff_dst = reg_dst_in0;
        unique case (reg_dst_sel)
            SEL_RD:  eff_dst = reg_dst_in0;
            SEL_RT:  eff_dst = reg_dst_in1;
            SEL_RA:  eff_dst = RA_IDX;
            SEL_SP:  eff_dst = SP_IDX;
            default: eff_dst = reg_dst_in0;
        endcase
    end

    // Writes to $zero still drain the stage but never reach the file.
    assign reg_write = (state == FULL) && !wb_stall && (eff_dst != ZERO_IDX);

    // ------------------------------------------------------------------
    // Completed-write counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= 16'h0000;
        end else if (reg_write && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'h0001;
        end
    end

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler. A behavioural
//               model of the write-back stage (occupancy flag, pointer,
//               held destination fields, data and write count) predicts every
//               output; directed scenarios and a randomized run compare the
//               DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic [4:0]  mem_rt = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] link_data = '0;
    logic [31:0] sp_data = '0;
    logic        wb_stall = 1'b0;
    logic        reg_write;
    logic [1:0]  reg_dst_sel;
    logic [4:0]  reg_dst_in0;
    logic [4:0]  reg_dst_in1;
    logic [31:0] reg_wdata;
    logic        busy;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    regfile_wb_scheduler #(.DATA_W(32), .REG_W(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_rt      (mem_rt),
        .mem_data    (mem_data),
        .link_data   (link_data),
        .sp_data     (sp_data),
        .wb_stall    (wb_stall),
        .reg_write   (reg_write),
        .reg_dst_sel (reg_dst_sel),
        .reg_dst_in0 (reg_dst_in0),
        .reg_dst_in1 (reg_dst_in1),
        .reg_wdata   (reg_wdata),
        .busy        (busy),
        .wr_count    (wr_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_full;
    int          m_ptr;
    logic [1:0]  m_sel;
    logic [4:0]  m_in0;
    logic [4:0]  m_in1;
    logic [31:0] m_wdata;
    int          m_count;

    function automatic void model_reset();
        m_full  = 0;
        m_ptr   = 0;
        m_sel   = 2'b00;
        m_in0   = '0;
        m_in1   = '0;
        m_wdata = '0;
        m_count = 0;
    endfunction

    function automatic logic [3:0] exp_ready();
        int i;
        if (!reset_n) return 4'b0000;
        if (m_full && wb_stall) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (req_valid[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    function automatic int exp_dst();
        case (m_sel)
            2'b00:   return int'(m_in0);
            2'b01:   return int'(m_in1);
            2'b10:   return 31;
            default: return 29;
        endcase
    endfunction

    function automatic logic exp_write();
        return m_full && !wb_stall && (exp_dst() != 0);
    endfunction

    // Advance one clock: predict from current inputs, wait for the edge,
    // apply the prediction, then settle 1 time unit past the edge.
    task automatic step();
        logic [3:0] rdy;
        logic       wr;
        int         g;
        rdy = exp_ready();
        wr  = exp_write();
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (wr && m_count < 65535) m_count++;
            if (rdy != 4'b0000) begin
                g = 0;
                for (int k = 0; k < 4; k++) if (rdy[k]) g = k;
                m_ptr  = (g + 1) % 4;
                m_sel  = 2'(g);
                m_full = 1;
                case (g)
                    0: begin m_in0 = alu_rd; m_wdata = alu_data; end
                    1: begin m_in1 = mem_rt; m_wdata = mem_data; end
                    2: m_wdata = link_data;
                    default: m_wdata = sp_data;
                endcase
            end else if (m_full && !wb_stall) begin
                m_full = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        wb_stall  = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        model_reset();
        #1;
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        total++;
        if ({reg_write, busy} !== 2'b00) begin bad++; $display("FAIL reset_write_busy: got %b want 00", {reg_write, busy}); end
        total++;
        if ({reg_dst_sel, reg_dst_in0, reg_dst_in1} !== 12'h000) begin
            bad++; $display("FAIL reset_dst: got sel=%b in0=%0d in1=%0d want 0", reg_dst_sel, reg_dst_in0, reg_dst_in1);
        end
        total++;
        if ({reg_wdata, wr_count} !== 48'h0) begin bad++; $display("FAIL reset_data_count: got wdata=%h cnt=%0d want 0", reg_wdata, wr_count); end
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        req_valid = '0;
        #1;
    endtask

    task automatic test_single_load();
        req_valid = 4'b0010;
        mem_rt    = 5'd8;
        mem_data  = 32'h1234;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        #1;
        total++;
        if (reg_write !== 1'b1 || reg_dst_sel !== 2'b01 || reg_dst_in1 !== 5'd8 || reg_wdata !== 32'h1234) begin
            bad++; $display("FAIL single_write: got we=%b sel=%b in1=%0d wdata=%h want 1 01 8 00001234",
                            reg_write, reg_dst_sel, reg_dst_in1, reg_wdata);
        end
        step();
        total++;
        if (wr_count !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL single_count: got cnt=%0d busy=%b want 1 0", wr_count, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        req_valid = 4'b1111;
        alu_rd    = 5'd3;
        mem_rt    = 5'd4;
        for (int c = 0; c < 8; c++) begin
            #1;
            want = 4'b0001 << (c % 4);
            total++;
            if (req_ready !== want) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, want); end
            if (c > 0) begin
                total++;
                if (reg_dst_sel !== 2'((c - 1) % 4) || reg_write !== 1'b1) begin
                    bad++; $display("FAIL rr_sel[%0d]: got sel=%b we=%b want %0d 1", c, reg_dst_sel, reg_write, (c - 1) % 4);
                end
            end
            step();
        end
        req_valid = '0;
        step();
        total++;
        if (wr_count !== 16'd8) begin bad++; $display("FAIL rr_count: got %0d want 8", wr_count); end
    endtask

    task automatic test_stall();
        req_valid = 4'b0001;
        alu_rd    = 5'd5;
        alu_data  = 32'hAAAA_5555;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL stall_accept: got %b want 0001", req_ready); end
        step();
        req_valid = 4'b1110;
        wb_stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (reg_write !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1 ||
                reg_dst_in0 !== 5'd5 || reg_dst_sel !== 2'b00 || reg_wdata !== 32'hAAAA_5555) begin
                bad++; $display("FAIL stall_hold[%0d]: got we=%b rdy=%b busy=%b in0=%0d sel=%b wdata=%h want 0 0000 1 5 00 aaaa5555",
                                c, reg_write, req_ready, busy, reg_dst_in0, reg_dst_sel, reg_wdata);
            end
            step();
        end
        req_valid = '0;
        wb_stall  = 1'b0;
        #1;
        total++;
        if (reg_write !== 1'b1 || reg_dst_in0 !== 5'd5) begin bad++; $display("FAIL stall_release: got we=%b in0=%0d want 1 5", reg_write, reg_dst_in0); end
        step();
        total++;
        if (wr_count !== 16'd9 || busy !== 1'b0) begin bad++; $display("FAIL stall_count: got cnt=%0d busy=%b want 9 0", wr_count, busy); end
    endtask

    task automatic test_zero_dst();
        req_valid = 4'b0001;
        alu_rd    = 5'd0;
        alu_data  = 32'h0BAD_0BAD;
        step();
        req_valid = '0;
        #1;
        total++;
        if (busy !== 1'b1 || reg_write !== 1'b0) begin bad++; $display("FAIL zero_fill: got busy=%b we=%b want 1 0", busy, reg_write); end
        step();
        total++;
        if (busy !== 1'b0 || wr_count !== 16'd9) begin bad++; $display("FAIL zero_drain: got busy=%b cnt=%0d want 0 9", busy, wr_count); end
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL zero_ptr: got %b want 0010", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        link_data = 32'hDEAD_BEEF;
        step();
        req_valid = '0;
        wb_stall  = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1 || reg_dst_sel !== 2'b10) begin bad++; $display("FAIL mid_pending: got busy=%b sel=%b want 1 10", busy, reg_dst_sel); end
        reset_n = 1'b0;
        #1;
        total++;
        if ({reg_write, busy, req_ready, reg_dst_sel, reg_wdata, wr_count} !== '0) begin
            bad++; $display("FAIL mid_reset: got we=%b busy=%b rdy=%b sel=%b wdata=%h cnt=%0d want all 0",
                            reg_write, busy, req_ready, reg_dst_sel, reg_wdata, wr_count);
        end
        step();
        wb_stall = 1'b0;
        reset_n  = 1'b1;
        #1;
        total++;
        if (reg_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_discard: got we=%b busy=%b want 0 0", reg_write, busy); end
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            wb_stall  = ($urandom_range(0, 3) == 0);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mem_rt    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_data  = $urandom;
            mem_data  = $urandom;
            link_data = $urandom;
            sp_data   = $urandom;
            #1;
            total++;
            if (req_ready !== exp_ready() || reg_write !== exp_write() || busy !== m_full) begin
                bad++; $display("FAIL rand_ctrl[%0d]: got rdy=%b we=%b busy=%b want %b %b %b",
                                c, req_ready, reg_write, busy, exp_ready(), exp_write(), m_full);
            end
            total++;
            if (reg_dst_sel !== m_sel || reg_dst_in0 !== m_in0 || reg_dst_in1 !== m_in1 ||
                reg_wdata !== m_wdata || wr_count !== 16'(m_count)) begin
                bad++; $display("FAIL rand_stage[%0d]: got sel=%b in0=%0d in1=%0d wdata=%h cnt=%0d want %b %0d %0d %h %0d",
                                c, reg_dst_sel, reg_dst_in0, reg_dst_in1, reg_wdata, wr_count,
                                m_sel, m_in0, m_in1, m_wdata, m_count);
            end
            step();
        end
        req_valid = '0;
        wb_stall  = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        req_valid = 4'b1111;
        wb_stall  = 1'b0;
        alu_rd    = 5'd1;
        mem_rt    = 5'd2;
        for (int c = 0; c < 65540; c++) begin
            step();
        end
        req_valid = '0;
        step();
        step();
        total++;
        if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count: got %h want ffff", wr_count); end
        total++;
        if (wr_count !== 16'(m_count)) begin bad++; $display("FAIL sat_model: got %0d want %0d", wr_count, m_count); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_stall();
        test_zero_dst();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the multicycle MIPS datapath. It shares the single register-file write port between four write-back sources: ALU result, memory load, jump-and-link return address, and stack-pointer update. It grants one source per cycle with round-robin priority and holds the winning write in a one-entry output stage. It drives the 2-bit destination-select flag and the two register-field inputs of the destination mux (`00` rd, `01` rt, `10` $31, `11` $29), together with the write enable and write data of the register file.

## Interface
- `DATA_W`, 32: write-data width.
- `REG_W`, 5: register-index width.
- `clock`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  4  per-source write request; [0] ALU, [1] load, [2] link, [3] stack.
- `req_ready`  out  4  per-source accept; at most one bit high.
- `alu_rd`  in  REG_W  destination for source 0.
- `alu_data`  in  DATA_W  data for source 0.
- `mem_rt`  in  REG_W  destination for source 1.
- `mem_data`  in  DATA_W  data for source 1.
- `link_data`  in  DATA_W  return address for source 2.
- `sp_data`  in  DATA_W  new stack pointer for source 3.
- `wb_stall`  in  1  control unit freezes the write port.
- `reg_write`  out  1  register-file write enable.
- `reg_dst_sel`  out  2  destination-mux flag.
- `reg_dst_in0`  out  REG_W  mux input 0 (rd).
- `reg_dst_in1`  out  REG_W  mux input 1 (rt).
- `reg_wdata`  out  DATA_W  register-file write data.
- `busy`  out  1  output stage occupied.
- `wr_count`  out  16  completed writes, saturating at 16'hFFFF.

## Operation
- **Transfer.** A transfer occurs on a rising edge when `req_valid[i] && req_ready[i]`.
- **Requester obligations.** A requester holds its valid, index and data stable until accepted.
- **Arbitration.** Round-robin over `req_valid` starting at `rr_ptr`. After each accept, `rr_ptr` becomes (granted index + 1) mod 4.
- **Ready condition.** `req_ready[g]` is high, combinationally, only when the stage can load: state EMPTY, or state FULL with `!wb_stall`.
- **Stage load.**
  - Source 0 loads sel `00`, `reg_dst_in0` = `alu_rd`.
  - Source 1 loads sel `01`, `reg_dst_in1` = `mem_rt`.
  - Source 2 loads sel `10`.
  - Source 3 loads sel `11`.
  - Register fields not used by the selected source hold their previous values.
- **Effective destination.** `eff_dst` = in0, in1, 31 or 29 for sel 00, 01, 10, 11.
- **Write enable.** `reg_write` = FULL && `!wb_stall` && `eff_dst != 0`. A write to $zero drains normally but never asserts `reg_write` and does not increment `wr_count`.
- **State machine.**
  - EMPTY → FULL on accept.
  - FULL → EMPTY when `!wb_stall` and no new accept.
  - FULL → FULL, stage replaced, when `!wb_stall` and an accept happens in the same cycle.
  - FULL holds its contents while `wb_stall` is high.
- **Write counter.** `wr_count` increments on each cycle with `reg_write` high and saturates at 16'hFFFF.

## Timing
- **Reset values.** On `reset_n` low, immediately:
  - state EMPTY, `rr_ptr` = 0;
  - all outputs 0, including `req_ready`, `reg_write`, `busy` and `wr_count`.
- **Reset mid-operation.** A write held in the stage is discarded and never issued.
- **Latency.** Accept at edge N → `reg_write` high during cycle N+1, provided `wb_stall` is low.
- **Throughput.** One write per cycle with continuous requests and no stall.
- **Outputs.** `reg_dst_sel`, `reg_dst_in0`, `reg_dst_in1`, `reg_wdata` and `busy` are registered. `reg_write` and `req_ready` are combinational from state and `wb_stall`.
- **Stall.** While `wb_stall` is high in FULL, `req_ready` is all zero and the stage outputs are frozen.
- **Simultaneous requests.** All four valid from reset → grant order 0, 1, 2, 3, 0, …
- **Late requester.** A requester dropping valid before being granted loses no state; arbitration re-evaluates every cycle.

## Structure
- Package `regwb_pkg`:
  - select encodings `SEL_RD` = 2'b00, `SEL_RT` = 2'b01, `SEL_RA` = 2'b10, `SEL_SP` = 2'b11;
  - register constants `REG_ZERO` = 0, `REG_RA` = 31, `REG_SP` = 29;
  - state enum {EMPTY, FULL};
  - source indices.
- One sub-module, `rr_arbiter4`: 4-way round-robin grant with pointer input and one-hot grant output.
- The top level holds the stage, FSM, pointer and counter.

## Test plan
1. **Single load.** Release reset; pulse `req_valid` = 4'b0010 with `mem_rt` = 8, `mem_data` = 32'h1234 → next cycle `reg_write` = 1, sel = 01, `reg_dst_in1` = 8, `reg_wdata` = 32'h1234, `wr_count` = 1.
2. **Round-robin order.** Hold all four valid for 8 cycles → grants 0, 1, 2, 3, 0, 1, 2, 3; sel sequence 00, 01, 10, 11 repeating; `wr_count` = 8.
3. **Stall hold.** Accept ALU (`alu_rd` = 5); hold `wb_stall` high 3 cycles → `reg_write` = 0, `req_ready` = 0, stage frozen. Release → one write to index 5.
4. **Zero destination.** ALU request with `alu_rd` = 0 → stage fills and drains, `reg_write` stays 0, `wr_count` unchanged, `rr_ptr` advances to 1.
5. **Reset mid-operation.** Assert `reset_n` low while FULL with the link write pending → that write never appears, all outputs 0. After release, first grant goes to source 0.
6. **Counter saturation.** Preload near saturation via 65 540 back-to-back writes → `wr_count` holds at 16'hFFFF.
